mux8_rr_scheduler: RTL

//  Round-robin scheduler that shares one 8:1 mux (the team's Mux8 cell, S2..S0 / D0..D7)

---
 rtl/mux8_rr_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters: one-hot grants
// with bounded hold time, registered mux selects and a registered sampled data bit.
module mux8_rr_scheduler #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       y_out,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_last_owner, w_last_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [7:0]       r_gnt, w_gnt_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_y, r_valid;
    logic             w_found;
    logic [2:0]       w_winner;
    logic             w_mux;

    // Search starts just past the last owner, so it naturally gets lowest priority.
    always_comb begin
        logic [2:0] idx;
        w_found  = 1'b0;
        w_winner = r_last_owner;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = r_last_owner + 3'(i);
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        case (r_sel)
            3'd0:    w_mux = data_in[0];
            3'd1:    w_mux = data_in[1];
            3'd2:    w_mux = data_in[2];
            3'd3:    w_mux = data_in[3];
            3'd4:    w_mux = data_in[4];
            3'd5:    w_mux = data_in[5];
            3'd6:    w_mux = data_in[6];
            default: w_mux = data_in[7];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_GRANT: begin
                if (!req[r_sel] || (r_hold_cnt == CNT_W'(HOLD_MAX))) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = r_sel;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            // Unreachable encodings fall through to idle behaviour.
            default: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                w_hold_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = 8'b1 << w_winner;
                    w_sel_nxt   = w_winner;
                    w_hold_nxt  = CNT_W'(1);
                    w_busy_nxt  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_owner <= 3'd7;
            r_hold_cnt   <= '0;
            r_gnt        <= '0;
            r_sel        <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_gnt        <= w_gnt_nxt;
            r_sel        <= w_sel_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Sample follows the registered grant, so y_out lags the granted cycle by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= 1'b0;
            r_valid <= 1'b0;
        end else if (|r_gnt) begin
            r_y     <= w_mux;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign y_out = r_y;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule
